seg_display_scan: RTL
=====================

Name: seg_display_scan

Overview:
- Reads the four BCD digits and the pause/adjust status produced by the level/score block: level10, level1, score10, score1, unpaused, adj.
- Time-multiplexes them onto the board's 4-digit common-anode seven-segment display.
- Latches one coherent snapshot of its inputs per scan frame.
- Blanks the leading level digit, blinks digits while paused or adjusting, and lights the decimal point as the level/score separator.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is driven (1 ms at 100 MHz); legal range ≥2.
- BLINK_DIV, 125: full scan frames per blink half-period; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- unpaused  in  1  game-running flag from the level/score block; 0 means paused
- adj  in  1  level-select/adjust mode
- level10  in  4  level tens digit, BCD
- level1  in  4  level units digit, BCD
- score10  in  4  score tens digit, BCD
- score1  in  4  score units digit, BCD
- an  out  4  anode enables, active low; an[0] is the rightmost digit
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (rst=1 at posedge): counters, idx, frame counter = 0; shadows = 0 with shadow unpaused = 1 and shadow adj = 0; blink_on = 1; outputs an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Reset mid-frame aborts the frame; there is no snapshot or frame_done for it.
- Refresh counter cnt counts 0..REFRESH_DIV-1.
- At cnt==REFRESH_DIV-1: cnt←0 and idx←(idx+1) mod 4 (2-bit wrap).
- Digit map, idx→source:
  - 0: score1
  - 1: score10
  - 2: level1
  - 3: level10
- Snapshot: at the cycle where cnt==REFRESH_DIV-1 and idx==3, all six inputs load into shadow registers. Display logic uses only shadows; inputs changing mid-frame never affect the current frame.
- frame_done: registered; high for exactly the one cycle after the snapshot edge.
- Blink: frame counter counts snapshot events 0..BLINK_DIV-1. On wrap, blink_on toggles. The counter and blink_on run continuously, regardless of pause.
- Output registers: an, seg and dp are registered from (idx, shadows, blink_on), one cycle of latency after idx changes.
  - an: one-hot low at bit idx.
  - dp: 0 only when idx==2 (separator); otherwise 1.
- Decode (0–9):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- Decode (other): values 10–15 show a dash, 0111111. A blanked digit shows 1111111 with its anode still asserted.
- Blanking priority, highest first:
  1. Blink-off: blink_on==0 blanks the selected digit, and its dp is also forced to 1, when either condition holds:
     - shadow adj==1 and idx∈{2,3};
     - shadow adj==0, shadow unpaused==0, any idx.
  2. Leading zero: idx==3 with shadow level10==0 → blank. A shadow level10 of 10–15 still shows a dash.
  3. Otherwise, decode the selected digit normally.
- Adjust takes precedence over paused: adj=1 with unpaused=0 blinks only the level digits.
- Single clock domain; inputs are assumed to be synchronous to clk.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
1. Reset: hold rst 3 cycles with arbitrary inputs → an=1111, seg=1111111, dp=1, frame_done=0. The first cycle after release shows an=1110, seg=1000000 (shadow 0).
2. Scan and snapshot: level=0,3 and score=4,2 applied before the first snapshot. In the second frame, each for 4 cycles:
   - an=1110, seg=0100100
   - an=1101, seg=0011001
   - an=1011, seg=0110000, dp=0
   - an=0111, seg=1111111
   - frame_done pulses once, at cycle 16 after reset release.
3. Snapshot coherence: change score1 2→7 while idx=1 → the remainder of that frame is unchanged; digit 0 shows 1111000 only in the next frame.
4. Pause blink: unpaused=0, adj=0 → all four digits blank for 2 frames, then display for 2 frames, repeating. Restoring unpaused=1 resumes a steady display from the next frame.
5. Adjust blink: adj=1, unpaused=0, level=0,5, score=1,9 → score digits remain steady. Digit 2 alternates between 0010010 and blank every 2 frames, with dp=1 in its off phase. Digit 3 stays blank (leading zero).
6. Invalid digit and mid-frame reset: score10=4'hC → digit 1 shows 0111111. Assert rst at idx=2 → outputs return to reset values next cycle, and no frame_done is emitted for the aborted frame.

Source files
------------

// File: rtl/seg_display_scan.sv
// Four-digit common-anode seven-segment scanner for the level/score display.
// Latches one input snapshot per frame; handles leading-zero blanking and pause/adjust blinking.
module seg_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       unpaused,
    input  logic       adj,
    input  logic [3:0] level10,
    input  logic [3:0] level1,
    input  logic [3:0] score10,
    input  logic [3:0] score1,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [FW-1:0] frame_cnt_r;
    logic          blink_on_r;
    logic [3:0]    sh_level10_r;
    logic [3:0]    sh_level1_r;
    logic [3:0]    sh_score10_r;
    logic [3:0]    sh_score1_r;
    logic          sh_unpaused_r;
    logic          sh_adj_r;

    logic          digit_end_s;
    logic          snap_s;
    logic          frame_wrap_s;
    logic [3:0]    digit_s;
    logic          blink_blank_s;
    logic          lead_blank_s;
    logic [3:0]    an_next_s;
    logic [6:0]    seg_next_s;
    logic          dp_next_s;

    assign digit_end_s  = (cnt_r == CNT_LAST);
    assign snap_s       = digit_end_s && (idx_r == 2'd3);
    assign frame_wrap_s = (frame_cnt_r == FRM_LAST);

    // Refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (digit_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Frame snapshot of all inputs; display logic sees only these shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_level10_r  <= 4'd0;
            sh_level1_r   <= 4'd0;
            sh_score10_r  <= 4'd0;
            sh_score1_r   <= 4'd0;
            sh_unpaused_r <= 1'b1;
            sh_adj_r      <= 1'b0;
        end else if (snap_s) begin
            sh_level10_r  <= level10;
            sh_level1_r   <= level1;
            sh_score10_r  <= score10;
            sh_score1_r   <= score1;
            sh_unpaused_r <= unpaused;
            sh_adj_r      <= adj;
        end else begin
            sh_level10_r  <= sh_level10_r;
            sh_level1_r   <= sh_level1_r;
            sh_score10_r  <= sh_score10_r;
            sh_score1_r   <= sh_score1_r;
            sh_unpaused_r <= sh_unpaused_r;
            sh_adj_r      <= sh_adj_r;
        end
    end

    // Blink phase advances on frame boundaries, independent of pause state.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= '0;
            blink_on_r  <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= snap_s;
            if (snap_s && frame_wrap_s) begin
                frame_cnt_r <= '0;
                blink_on_r  <= ~blink_on_r;
            end else if (snap_s) begin
                frame_cnt_r <= frame_cnt_r + FW'(1);
                blink_on_r  <= blink_on_r;
            end else begin
                frame_cnt_r <= frame_cnt_r;
                blink_on_r  <= blink_on_r;
            end
        end
    end

    // Select the shadowed digit for the current index.
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            2'd0:    digit_s = sh_score1_r;
            2'd1:    digit_s = sh_score10_r;
            2'd2:    digit_s = sh_level1_r;
            2'd3:    digit_s = sh_level10_r;
            default: digit_s = 4'd0;
        endcase
    end

    // Blank priority: blink-off, then leading zero, then normal decode.
    always_comb begin
        blink_blank_s = 1'b0;
        lead_blank_s  = 1'b0;
        an_next_s     = ~(4'b0001 << idx_r);
        seg_next_s    = 7'h7F;
        dp_next_s     = 1'b1;
        if (sh_adj_r) begin
            blink_blank_s = ~blink_on_r && (idx_r >= 2'd2);
        end else begin
            blink_blank_s = ~blink_on_r && ~sh_unpaused_r;
        end
        lead_blank_s = (idx_r == 2'd3) && (sh_level10_r == 4'd0);
        if (blink_blank_s || lead_blank_s) begin
            seg_next_s = 7'h7F;
        end else begin
            seg_next_s = decode_bcd(digit_s);
        end
        if ((idx_r == 2'd2) && !blink_blank_s) begin
            dp_next_s = 1'b0;
        end else begin
            dp_next_s = 1'b1;
        end
    end

    // Registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next_s;
            seg <= seg_next_s;
            dp  <= dp_next_s;
        end
    end

endmodule
